// File: rtl/lag_pl_credit_tracker.sv
// Per (output port, PL) credit counters driving the blocked/ready status vector.
// Optional protocol checking is enabled by defining LAG_CREDIT_CHECK_EN.
module lag_pl_credit_tracker #(
  parameter int np      = 5,
  parameter int nv      = 4,
  parameter int buf_len = 4,
  localparam int cw     = $clog2(buf_len + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [np-1:0][nv-1:0]           flit_sent,
  input  logic [np-1:0][nv-1:0]           credit_in,
  output logic [np-1:0][nv-1:0]           pl_status,
  output logic [np-1:0][nv-1:0][cw-1:0]   credit_cnt,
  output logic [np-1:0][nv-1:0]           credit_err
);

  localparam logic [cw-1:0] full_cnt = cw'(buf_len);

  logic [np-1:0][nv-1:0][cw-1:0] cnt_nxt;

  // Saturating update: an illegal send at 0 or an illegal credit at full holds.
  always_comb begin
    cnt_nxt = credit_cnt;
    for (int p = 0; p < np; p++) begin
      for (int v = 0; v < nv; v++) begin
        if (flit_sent[p][v] && !credit_in[p][v] && credit_cnt[p][v] != '0)
          cnt_nxt[p][v] = credit_cnt[p][v] - 1'b1;
        else if (credit_in[p][v] && !flit_sent[p][v] && credit_cnt[p][v] != full_cnt)
          cnt_nxt[p][v] = credit_cnt[p][v] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < np; p++)
        for (int v = 0; v < nv; v++)
          credit_cnt[p][v] <= full_cnt;
      pl_status <= '0;
    end else begin
      credit_cnt <= cnt_nxt;
      for (int p = 0; p < np; p++)
        for (int v = 0; v < nv; v++)
          pl_status[p][v] <= (cnt_nxt[p][v] == '0);
    end
  end

`ifdef LAG_CREDIT_CHECK_EN
  logic [np-1:0][nv-1:0] err_set;

  always_comb begin
    err_set = '0;
    for (int p = 0; p < np; p++) begin
      for (int v = 0; v < nv; v++) begin
        err_set[p][v] = (flit_sent[p][v] && !credit_in[p][v] && credit_cnt[p][v] == '0) ||
                        (credit_in[p][v] && !flit_sent[p][v] && credit_cnt[p][v] == full_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credit_err <= '0;
    end else begin
      credit_err <= credit_err | err_set;
`ifndef SYNTHESIS
      for (int p = 0; p < np; p++)
        for (int v = 0; v < nv; v++)
          if (err_set[p][v])
            $display("%m: credit protocol violation on port %0d pl %0d (cnt=%0d)",
                     p, v, credit_cnt[p][v]);
`endif
    end
  end
`else
  assign credit_err = '0;
`endif

endmodule

// File: tb/tb_lag_pl_credit_tracker.sv
// Directed and scoreboarded checks for lag_pl_credit_tracker (default 5x4x4 plus a 1x1 buf_len=1 instance).
module tb_lag_pl_credit_tracker;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0][3:0]      flit_sent, credit_in, pl_status, credit_err;
  logic [4:0][3:0][2:0] credit_cnt;

  logic [0:0][0:0]      s1_sent, s1_cred, s1_status, s1_err;
  logic [0:0][0:0][0:0] s1_cnt;

  int total = 0;
  int bad   = 0;

  logic [4:0][3:0][2:0] exp_cnt;
  logic [4:0][3:0]      exp_stat, exp_err;
  int                   mdl [5][4];
  bit                   chk_en;

  always #5 clk = ~clk;

  lag_pl_credit_tracker #(.np(5), .nv(4), .buf_len(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .flit_sent(flit_sent), .credit_in(credit_in),
    .pl_status(pl_status), .credit_cnt(credit_cnt), .credit_err(credit_err)
  );

  lag_pl_credit_tracker #(.np(1), .nv(1), .buf_len(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flit_sent(s1_sent), .credit_in(s1_cred),
    .pl_status(s1_status), .credit_cnt(s1_cnt), .credit_err(s1_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [59:0] all_cnt(input int val);
    logic [4:0][3:0][2:0] r;
    for (int p = 0; p < 5; p++)
      for (int v = 0; v < 4; v++)
        r[p][v] = 3'(val);
    return r;
  endfunction

  initial begin
`ifdef LAG_CREDIT_CHECK_EN
    chk_en = 1'b1;
`else
    chk_en = 1'b0;
`endif
    rst_n = 1'b0;
    flit_sent = '0; credit_in = '0; s1_sent = '0; s1_cred = '0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("reset_cnt", credit_cnt, all_cnt(4));
    chk("reset_status", pl_status, '0);
    chk("reset_err", credit_err, '0);

    // four sends on port 2 PL 1: 3,2,1,0, blocked only after the 4th edge
    flit_sent[2][1] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("drain_cnt_%0d", k), credit_cnt[2][1], 64'(4 - k));
      chk($sformatf("drain_stat_%0d", k), pl_status[2][1], (k == 4) ? 64'd1 : 64'd0);
    end
    flit_sent = '0;
    exp_cnt = all_cnt(4);
    exp_cnt[2][1] = 3'd0;
    chk("drain_others_cnt", credit_cnt, exp_cnt);
    exp_stat = '0;
    exp_stat[2][1] = 1'b1;
    chk("drain_others_stat", pl_status, exp_stat);
    tick();
    chk("blocked_hold", credit_cnt[2][1], 0);

    credit_in[2][1] = 1'b1;
    tick();
    credit_in = '0;
    chk("unblock_cnt", credit_cnt[2][1], 1);
    chk("unblock_stat", pl_status[2][1], 0);
    flit_sent[2][1] = 1'b1; credit_in[2][1] = 1'b1;
    tick();
    flit_sent = '0; credit_in = '0;
    chk("both_cnt", credit_cnt[2][1], 1);
    chk("both_stat", pl_status[2][1], 0);

    // underflow on port 0 PL 3
    flit_sent[0][3] = 1'b1;
    repeat (4) tick();
    chk("uf_pre_cnt", credit_cnt[0][3], 0);
    chk("uf_pre_err", credit_err, '0);
    tick();
    flit_sent = '0;
    chk("uf_cnt", credit_cnt[0][3], 0);
    chk("uf_stat", pl_status[0][3], 1);
    exp_err = '0;
    exp_err[0][3] = chk_en;
    chk("uf_err", credit_err, exp_err);

    // overflow on port 4 PL 0
    credit_in[4][0] = 1'b1;
    tick();
    credit_in = '0;
    chk("of_cnt", credit_cnt[4][0], 4);
    chk("of_stat", pl_status[4][0], 0);
    exp_err[4][0] = chk_en;
    chk("of_err", credit_err, exp_err);
    tick();
    chk("err_sticky", credit_err, exp_err);

    // buf_len==1 instance alternates on each send/credit
    chk("b1_reset_cnt", s1_cnt, 1);
    for (int k = 0; k < 4; k++) begin
      s1_sent = (k % 2 == 0); s1_cred = (k % 2 == 1);
      tick();
      chk($sformatf("b1_cnt_%0d", k), s1_cnt, (k % 2 == 0) ? 64'd0 : 64'd1);
      chk($sformatf("b1_stat_%0d", k), s1_status, (k % 2 == 0) ? 64'd1 : 64'd0);
    end
    s1_sent = '0; s1_cred = '0;
    chk("b1_err", s1_err, 0);

    // scoreboarded legal random traffic with a one-cycle reset mid-run
    for (int p = 0; p < 5; p++)
      for (int v = 0; v < 4; v++)
        mdl[p][v] = int'(credit_cnt[p][v] == 3'd0 ? 0 : 0) + int'(exp_cnt[p][v]);
    mdl[2][1] = 1; mdl[0][3] = 0; mdl[4][0] = 4;
    for (int it = 0; it < 120; it++) begin
      rst_n = (it != 60);
      for (int p = 0; p < 5; p++) begin
        for (int v = 0; v < 4; v++) begin
          flit_sent[p][v] = ($urandom_range(0, 1) == 1) && (mdl[p][v] > 0);
          credit_in[p][v] = ($urandom_range(0, 2) != 0) && (mdl[p][v] < 4 || flit_sent[p][v]);
          if (!rst_n) mdl[p][v] = 4;
          else if (flit_sent[p][v] && !credit_in[p][v]) mdl[p][v]--;
          else if (credit_in[p][v] && !flit_sent[p][v]) mdl[p][v]++;
          exp_cnt[p][v] = 3'(mdl[p][v]);
          exp_stat[p][v] = (mdl[p][v] == 0);
        end
      end
      if (!rst_n) exp_err = '0;
      tick();
      chk($sformatf("rnd_cnt_%0d", it), credit_cnt, exp_cnt);
      chk($sformatf("rnd_stat_%0d", it), pl_status, exp_stat);
      chk($sformatf("rnd_err_%0d", it), credit_err, exp_err);
      if (it == 60) begin
        chk("rst_all_full", credit_cnt, all_cnt(4));
        chk("rst_err_clear", credit_err, '0);
      end
    end
    rst_n = 1'b1;
    flit_sent = '0; credit_in = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
